// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Scan codes, key indices, receiver states and the key map lookup.
package ps2_key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;
    localparam int NUM_KEYS  = 5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    function automatic key_hit_t key_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 3'(KEY_UP);
        unique case (1'b1)
            (code == SC_UP)    || (code == SC_W): r.idx = 3'(KEY_UP);
            (code == SC_DOWN)  || (code == SC_S): r.idx = 3'(KEY_DOWN);
            (code == SC_LEFT)  || (code == SC_A): r.idx = 3'(KEY_LEFT);
            (code == SC_RIGHT) || (code == SC_D): r.idx = 3'(KEY_RIGHT);
            (code == SC_ENTER):                   r.idx = 3'(KEY_ENTER);
            default:                              r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame receiver.
// Emits one-cycle good-byte and frame-error strobes.
module ps2_rx_frame
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rst_sys,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_LEN - 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          clk_filt, dat_filt;
    logic [FW-1:0] clk_cnt, dat_cnt;
    logic          clk_flip, dat_flip, fall;

    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n, byte_n;
    logic          par, par_n, ok_n, err_n;
    logic [TW-1:0] tcnt, tcnt_n;

    // two-flop synchronisers, idle-high
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    assign clk_flip = (clk_sync != clk_filt) && (clk_cnt == CNT_LAST);
    assign dat_flip = (dat_sync != dat_filt) && (dat_cnt == CNT_LAST);
    // strobe coincides with the filtered clock going low
    assign fall     = clk_flip & clk_filt;

    // clock filter: flip only after FILTER_LEN differing samples
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
        end else if (clk_sync == clk_filt) begin
            clk_cnt  <= '0;
        end else if (clk_flip) begin
            clk_filt <= clk_sync;
            clk_cnt  <= '0;
        end else begin
            clk_cnt  <= clk_cnt + 1'b1;
        end
    end

    // data filter, same rule as the clock
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            dat_filt <= 1'b1;
            dat_cnt  <= '0;
        end else if (dat_sync == dat_filt) begin
            dat_cnt  <= '0;
        end else if (dat_flip) begin
            dat_filt <= dat_sync;
            dat_cnt  <= '0;
        end else begin
            dat_cnt  <= dat_cnt + 1'b1;
        end
    end

    // receiver state and strobe registers
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tcnt     <= '0;
            rx_byte  <= '0;
            byte_ok  <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par      <= par_n;
            tcnt     <= tcnt_n;
            rx_byte  <= byte_n;
            byte_ok  <= ok_n;
            byte_err <= err_n;
        end
    end

    // frame sequencing; a timeout abort may restart on the same edge
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        byte_n  = rx_byte;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        tcnt_n  = (fall || state == RX_IDLE) ? '0 : tcnt + 1'b1;
        if (state != RX_IDLE && tcnt == TW'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = RX_IDLE;
            tcnt_n  = '0;
            if (fall && !dat_filt) begin
                state_n = RX_DATA;
                bit_n   = '0;
            end
        end else if (fall) begin
            unique case (state)
                RX_IDLE: begin
                    if (!dat_filt) begin
                        state_n = RX_DATA;
                        bit_n   = '0;
                    end
                end
                RX_DATA: begin
                    shift_n = {dat_filt, shift[7:1]};
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_n   = dat_filt;
                    state_n = RX_STOP;
                end
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (dat_filt && (^{shift, par})) begin
                        ok_n   = 1'b1;
                        byte_n = shift;
                    end else begin
                        err_n  = 1'b1;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 make/break decoder producing one-shot game-control pulses.
// Held keys suppress typematic repeat until their break code.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rst_sys,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       enter,
    output logic [4:0] held,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0]          rx_byte;
    logic                byte_ok, byte_err;
    logic                ext, brk;
    logic [NUM_KEYS-1:0] pulse;
    key_hit_t            hit;
    logic                unused_ext;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk      (clk),
        .rst_sys  (rst_sys),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_ok  (byte_ok),
        .byte_err (byte_err)
    );

    assign hit = key_lookup(rx_byte);

    // no mapped key depends on E0; it only frames the sequence
    assign unused_ext = ext;

    assign up    = pulse[KEY_UP];
    assign down  = pulse[KEY_DOWN];
    assign left  = pulse[KEY_LEFT];
    assign right = pulse[KEY_RIGHT];
    assign enter = pulse[KEY_ENTER];

    // prefix tracking, held state and registered one-cycle outputs
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            held       <= '0;
            pulse      <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pulse      <= '0;
            scan_valid <= byte_ok;
            frame_err  <= byte_err;
            if (byte_ok) begin
                scan_code <= rx_byte;
                unique case (1'b1)
                    rx_byte == SC_EXT: ext <= 1'b1;
                    rx_byte == SC_BRK: brk <= 1'b1;
                    default: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                        if (hit.hit) begin
                            if (brk) begin
                                held[hit.idx] <= 1'b0;
                            end else if (!held[hit.idx]) begin
                                held[hit.idx]  <= 1'b1;
                                pulse[hit.idx] <= 1'b1;
                            end
                        end
                    end
                endcase
            end else if (byte_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder.
// Frames are bit-banged on the PS/2 lines; expected events are queued.
module tb_ps2_key_decoder;
    import ps2_key_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_sys = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up, down, left, right, enter;
    logic [4:0] held;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;
    logic [4:0] pulses;

    int          checks = 0;
    int          failures = 0;
    logic [14:0] exp_q[$];
    logic [14:0] obs;
    logic [4:0]  m_held = '0;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_sys    (rst_sys),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .enter      (enter),
        .held       (held),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    assign pulses = {enter, right, left, down, up};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // every cycle with any output activity must match the next expected event
    always @(negedge clk) begin
        if (scan_valid || frame_err || (|pulses)) begin
            obs = {frame_err, pulses, scan_valid,
                   scan_valid ? scan_code : 8'h00};
            if (exp_q.size() == 0)
                check("unexpected", 32'(obs), 32'h0);
            else
                check("event", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    function automatic int key_of(input logic [7:0] b);
        case (b)
            8'h75, 8'h1D: return 0;
            8'h72, 8'h1B: return 1;
            8'h6B, 8'h1C: return 2;
            8'h74, 8'h23: return 3;
            8'h5A:        return 4;
            default:      return -1;
        endcase
    endfunction

    task automatic expect_frame(input logic [7:0] b, input bit bad);
        logic [4:0] pv;
        int k;
        pv = '0;
        if (bad) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            exp_q.push_back(15'h4000);
        end else begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                k = key_of(b);
                if (k >= 0) begin
                    if (m_brk) m_held[k] = 1'b0;
                    else if (!m_held[k]) begin
                        m_held[k] = 1'b1;
                        pv[k] = 1'b1;
                    end
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            exp_q.push_back({1'b0, pv, 1'b1, b});
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = (~^b) ^ bad;
        expect_frame(b, bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        wait_cycles(HALF);
        check("held", 32'(held), 32'(m_held));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(5);
        check("reset_outs",
              32'({held, scan_code, scan_valid, frame_err, pulses}), 32'h0);
        rst_sys = 1'b0;
        wait_cycles(20);

        // make, break, make of Enter
        send_frame(8'h5A, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);

        // typematic E0 75 then its break
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hE0, 1'b0);
            send_frame(8'h75, 1'b0);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);

        // parity error, then the good frame
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);

        // E0 then a stalled frame that times out
        send_frame(8'hE0, 1'b0);
        expect_frame(8'h00, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(TO + 10);
        check("timeout_drain", 32'(exp_q.size()), 32'h0);
        wait_cycles(HALF);
        send_frame(8'h74, 1'b0);

        // sub-threshold glitches on an idle bus
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            wait_cycles(FL - 1);
            ps2_clk = 1'b1;
            wait_cycles(30);
        end
        check("glitch_held", 32'(held), 32'(m_held));

        // reset after the 4th data bit of 23
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        rst_sys = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(20);
        check("mid_reset_outs",
              32'({held, scan_code, scan_valid, frame_err, pulses}), 32'h0);
        rst_sys = 1'b0;
        m_held = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cycles(HALF);
        check("post_reset_held", 32'(held), 32'h0);
        send_frame(8'h23, 1'b0);

        wait_cycles(50);
        check("pending", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
